// File: rtl/axi_regbank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
package axi_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    localparam logic [31:0] REGBANK_ID = 32'hdeadbeef;

    // Byte-offset bits below the register index in an AXI address.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with RO masking, access pulses and SLVERR decode.
// Optional macro AXI_REGBANK_ID_EN: registers 0/1 become read-only ID and geometry words.
module axi_lite_regbank
    import axi_regbank_pkg::*;
#(
    parameter int unsigned                     DATA_WIDTH  = 32,
    parameter int unsigned                     NUM_REGS    = 16,
    parameter int unsigned                     ADDR_WIDTH  = 6,
    parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] slv_reg,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] slv_read,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int unsigned LSB    = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W  = ADDR_WIDTH - LSB;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                  ready_en;
    logic                  aw_held, w_held, ar_held;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  commit, capture, aw_hit, ar_hit;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_val [NUM_REGS];
    logic [DATA_WIDTH-1:0] cur_val, merged, rd_sel;
    logic [NUM_REGS-1:0]   ro_eff;
    resp_t                 bresp_q, rresp_q;
    logic                  unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
    assign aw_hit      = 32'(aw_idx) < NUM_REGS;
    assign ar_hit      = 32'(ar_idx) < NUM_REGS;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RRESP = rresp_q;

`ifdef AXI_REGBANK_ID_EN
    assign ro_eff = RO_MASK | NUM_REGS'(2'b11);
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
            rd_val[i] = slv_read[i*DATA_WIDTH +: DATA_WIDTH];
        rd_val[0] = DATA_WIDTH'(REGBANK_ID);
        rd_val[1] = DATA_WIDTH'({16'(NUM_REGS), 16'(DATA_WIDTH)});
    end
`else
    assign ro_eff = RO_MASK;
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
            rd_val[i] = slv_read[i*DATA_WIDTH +: DATA_WIDTH];
    end
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign slv_reg[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

    // ---------------- write channel ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) wr_state <= WR_IDLE;
        else                wr_state <= wr_state_next;
    end

    always_comb begin
        wr_state_next = wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        commit        = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                S_AXI_AWREADY = ready_en && !aw_held;
                S_AXI_WREADY  = ready_en && !w_held;
                if (aw_held && w_held) begin
                    commit        = 1'b1;
                    wr_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        cur_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (32'(aw_idx) == i) cur_val = regs[i];
    end

    for (genvar b = 0; b < STRB_W; b++) begin : g_merge
        assign merged[b*8 +: 8] = w_strb[b] ? w_data[b*8 +: 8] : cur_val[b*8 +: 8];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bresp_q  <= OKAY;
            wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            ready_en <= 1'b1;
            wr_pulse <= '0;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= aw_hit ? OKAY : SLVERR;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (32'(aw_idx) == i && !ro_eff[i]) begin
                        regs[i]     <= merged;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- read channel ----------------
    // The address is latched first and data captured on the following edge,
    // mirroring the write path's one-cycle handshake-to-response latency.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rd_state <= RD_IDLE;
        else                rd_state <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        capture       = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                S_AXI_ARREADY = ready_en && !ar_held;
                if (ar_held) begin
                    capture       = 1'b1;
                    rd_state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (32'(ar_idx) == i) rd_sel = rd_val[i];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ar_held     <= 1'b0;
            ar_idx      <= '0;
            S_AXI_RDATA <= '0;
            rresp_q     <= OKAY;
            rd_pulse    <= '0;
        end else begin
            rd_pulse <= '0;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                ar_held <= 1'b1;
                ar_idx  <= S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
            end
            if (capture) begin
                ar_held     <= 1'b0;
                S_AXI_RDATA <= ar_hit ? rd_sel : '0;
                rresp_q     <= ar_hit ? OKAY : SLVERR;
                for (int unsigned i = 0; i < NUM_REGS; i++)
                    if (32'(ar_idx) == i) rd_pulse[i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed corner cases plus randomized traffic vs. a register-array model.
module tb_axi_lite_regbank;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned AW = 8;
    localparam logic [NR-1:0]    RO  = 16'h0010;
    localparam logic [NR*DW-1:0] RST = ((NR*DW)'(32'h0000_0005) << (4*DW)) |
                                       ((NR*DW)'(32'hCAFE_0007) << (7*DW));

    logic             clk, rst_n;
    logic [AW-1:0]    aw_addr, ar_addr;
    logic [2:0]       aw_prot, ar_prot;
    logic             aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic             ar_valid, ar_ready, r_valid, r_ready;
    logic [DW-1:0]    w_data, r_data;
    logic [DW/8-1:0]  w_strb;
    logic [1:0]       b_resp, r_resp;
    logic [NR*DW-1:0] slv_reg, slv_read;
    logic [NR-1:0]    wr_pulse, rd_pulse;

    logic             ovr_en;
    logic [DW-1:0]    ovr_val1;
    logic [DW-1:0]    model [NR];
    logic [NR*DW-1:0] rst_vec;
    logic [NR-1:0]    ro_vec;
    int unsigned      n_cmp = 0;
    int unsigned      n_bad = 0;

    axi_lite_regbank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW),
        .RO_MASK    (RO),
        .RESET_VALUE(RST)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (aw_addr),
        .S_AXI_AWPROT (aw_prot),
        .S_AXI_AWVALID(aw_valid),
        .S_AXI_AWREADY(aw_ready),
        .S_AXI_WDATA  (w_data),
        .S_AXI_WSTRB  (w_strb),
        .S_AXI_WVALID (w_valid),
        .S_AXI_WREADY (w_ready),
        .S_AXI_BRESP  (b_resp),
        .S_AXI_BVALID (b_valid),
        .S_AXI_BREADY (b_ready),
        .S_AXI_ARADDR (ar_addr),
        .S_AXI_ARPROT (ar_prot),
        .S_AXI_ARVALID(ar_valid),
        .S_AXI_ARREADY(ar_ready),
        .S_AXI_RDATA  (r_data),
        .S_AXI_RRESP  (r_resp),
        .S_AXI_RVALID (r_valid),
        .S_AXI_RREADY (r_ready),
        .slv_reg      (slv_reg),
        .slv_read     (slv_read),
        .wr_pulse     (wr_pulse),
        .rd_pulse     (rd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // User logic loops registers back, except register 1 may be overridden.
    always_comb begin
        slv_read = slv_reg;
        if (ovr_en) slv_read[DW +: DW] = ovr_val1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_ro(input int unsigned idx);
`ifdef AXI_REGBANK_ID_EN
        if (idx < 2) return 1'b1;
`endif
        return ro_vec[idx];
    endfunction

    function automatic logic [DW-1:0] exp_read(input int unsigned idx);
        if (idx >= NR) return '0;
`ifdef AXI_REGBANK_ID_EN
        if (idx == 0) return 32'hdeadbeef;
        if (idx == 1) return {16'(NR), 16'(DW)};
`endif
        if (idx == 1 && ovr_en) return ovr_val1;
        return model[idx];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NR; i++) model[i] = rst_vec[i*DW +: DW];
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < NR; i++) check(tag, slv_reg[i*DW +: DW], model[i]);
    endtask

    task automatic axi_write(input int unsigned idx, input logic [DW-1:0] data, input logic [3:0] strb,
                             input int unsigned aw_delay, input int unsigned w_delay,
                             input int unsigned b_delay);
        bit            aw_done = 0, w_done = 0, aw_fire, w_fire;
        int unsigned   k = 0;
        logic [1:0]    exp_resp;
        logic [NR-1:0] exp_pulse = '0;
        logic [DW-1:0] nv = '0;
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        if (idx < NR && !is_ro(idx)) begin
            nv = model[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) nv[b*8 +: 8] = data[b*8 +: 8];
            exp_pulse[idx] = 1'b1;
        end
        @(negedge clk);
        aw_addr = AW'(idx * 4 + $urandom_range(0, 3));
        aw_prot = 3'($urandom);
        w_data  = data;
        w_strb  = strb;
        while (!(aw_done && w_done) && k < 50) begin
            aw_valid = !aw_done && (k >= aw_delay);
            w_valid  = !w_done && (k >= w_delay);
            aw_fire  = aw_valid && aw_ready;
            w_fire   = w_valid && w_ready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            @(negedge clk);
            k++;
        end
        aw_valid = 0;
        w_valid  = 0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        check("bvalid_early", 64'(b_valid), 64'd0);
        @(negedge clk);
        check("bvalid_latency", 64'(b_valid), 64'd1);
        check("bresp", 64'(b_resp), 64'(exp_resp));
        check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
        if (exp_pulse != '0) model[idx] = nv;
        for (int unsigned j = 0; j < b_delay; j++) @(negedge clk);
        b_ready = 1;
        k = 0;
        while (!b_valid && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        b_ready = 0;
        check("bvalid_drop", 64'(b_valid), 64'd0);
        check("wr_pulse_width", 64'(wr_pulse), 64'd0);
        if (idx < NR) check("slv_reg_target", slv_reg[idx*DW +: DW], model[idx]);
        else          check_bank("slv_reg_unchanged");
    endtask

    task automatic axi_read(input int unsigned idx, input int unsigned r_delay, input bit clear_mid);
        int unsigned   k = 0;
        logic [DW-1:0] exp_d;
        logic [NR-1:0] exp_pulse = '0;
        if (idx < NR) exp_pulse[idx] = 1'b1;
        @(negedge clk);
        ar_addr  = AW'(idx * 4 + $urandom_range(0, 3));
        ar_prot  = 3'($urandom);
        ar_valid = 1;
        while (!ar_ready && k < 50) begin @(negedge clk); k++; end
        if (!ar_ready) begin
            ar_valid = 0;
            check("rd_handshake_timeout", 64'd0, 64'd1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        ar_valid = 0;
        exp_d    = exp_read(idx);
        check("rvalid_early", 64'(r_valid), 64'd0);
        @(negedge clk);
        check("rvalid_latency", 64'(r_valid), 64'd1);
        check("rdata", 64'(r_data), 64'(exp_d));
        check("rresp", 64'(r_resp), (idx < NR) ? 64'd0 : 64'd2);
        check("rd_pulse", 64'(rd_pulse), 64'(exp_pulse));
        if (clear_mid) ovr_val1 = '0;
        for (int unsigned j = 0; j < r_delay; j++) begin
            @(negedge clk);
            check("rdata_hold", 64'(r_data), 64'(exp_d));
            check("rvalid_hold", 64'(r_valid), 64'd1);
        end
        r_ready = 1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 0;
        check("rvalid_drop", 64'(r_valid), 64'd0);
        check("rd_pulse_width", 64'(rd_pulse), 64'd0);
    endtask

    initial begin
        int unsigned k;
        rst_vec  = RST;
        ro_vec   = RO;
        rst_n    = 0;
        aw_addr  = '0; aw_prot = '0; aw_valid = 0;
        w_data   = '0; w_strb  = '0; w_valid  = 0; b_ready = 0;
        ar_addr  = '0; ar_prot = '0; ar_valid = 0; r_ready = 0;
        ovr_en   = 0;
        ovr_val1 = '0;
        reset_model();

        #13;
        check("rst_awready", 64'(aw_ready), 64'd0);
        check("rst_wready", 64'(w_ready), 64'd0);
        check("rst_arready", 64'(ar_ready), 64'd0);
        check("rst_bvalid", 64'(b_valid), 64'd0);
        check("rst_rvalid", 64'(r_valid), 64'd0);
        check("rst_bresp", 64'(b_resp), 64'd0);
        check("rst_rresp", 64'(r_resp), 64'd0);
        check("rst_rdata", 64'(r_data), 64'd0);
        check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("rst_rd_pulse", 64'(rd_pulse), 64'd0);
        check_bank("rst_slv_reg");
        repeat (2) @(negedge clk);
        rst_n = 1;

        axi_write(2, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_write(3, 32'hAABB_CCDD, 4'b0101, 3, 0, 1);
        check("strb_merge", slv_reg[3*DW +: DW], 64'h00BB_00DD);
        axi_read(16, 0, 0);
        axi_write(20, 32'hDEAD_0000, 4'hF, 0, 1, 0);
        axi_write(4, 32'hFFFF_FFFF, 4'hF, 1, 0, 2);
        check("ro_keep", slv_reg[4*DW +: DW], 64'h5);

        ovr_en   = 1;
        ovr_val1 = 32'h7654_3210;
        axi_read(1, 5, 1);
        ovr_en   = 0;

        axi_read(0, 0, 0);
        axi_read(2, 1, 0);

        // Park a committed write in its response phase and a read in its data phase, then reset.
        @(negedge clk);
        aw_addr  = AW'(7 * 4);
        w_data   = 32'h1111_1111;
        w_strb   = 4'hF;
        aw_valid = 1;
        w_valid  = 1;
        ar_addr  = AW'(2 * 4);
        ar_valid = 1;
        k = 0;
        while (!(aw_ready && w_ready && ar_ready) && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        aw_valid = 0; w_valid = 0; ar_valid = 0;
        k = 0;
        while (!(b_valid && r_valid) && k < 20) begin @(negedge clk); k++; end
        check("pre_rst_bvalid", 64'(b_valid), 64'd1);
        check("pre_rst_rvalid", 64'(r_valid), 64'd1);
        check("pre_rst_reg7", slv_reg[7*DW +: DW], 64'h1111_1111);
        #2 rst_n = 0;
        #1;
        check("midrst_bvalid", 64'(b_valid), 64'd0);
        check("midrst_rvalid", 64'(r_valid), 64'd0);
        check("midrst_awready", 64'(aw_ready), 64'd0);
        check("midrst_arready", 64'(ar_ready), 64'd0);
        check("midrst_rdata", 64'(r_data), 64'd0);
        reset_model();
        check_bank("midrst_slv_reg");
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write($urandom_range(0, 19), $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read($urandom_range(0, 19), $urandom_range(0, 3), 0);
        end
        check_bank("final_slv_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
